// File: rtl/universal_shift_register_pkg.sv
// universal_shift_register_pkg: shared mode and state encodings for the universal shift register
// Constraint: 2**CW must exceed N so the step counter can hold any amount up to N and beyond.
package universal_shift_register_pkg;
   typedef enum logic [2:0] {
      MODE_NOP  = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_RSV  = 3'b111
   } mode_t;
   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/shift_step_unit.sv
// shift_step_unit: combinational single-bit step for the shift modes
// Ports: cur (current register), mode (latched shift mode), sin (serial fill),
//        nxt (value after one step), bout (bit that leaves the register).
module shift_step_unit
   import universal_shift_register_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] cur,
   input  mode_t        mode,
   input  logic         sin,
   output logic [N-1:0] nxt,
   output logic         bout
);
   logic left;
   logic fill;
   assign left = (mode == MODE_SHL) || (mode == MODE_ROL);
   // Fill bit: serial input for logical shifts, wrapped bit for rotates, sign for ASR.
   assign fill = ((mode == MODE_SHL) || (mode == MODE_SHR)) ? sin :
                 ((mode == MODE_ROL) || (mode == MODE_ASR)) ? cur[N-1] : cur[0];
   assign nxt  = left ? {cur[N-2:0], fill} : {fill, cur[N-1:1]};
   assign bout = left ? cur[N-1] : cur[0];
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: N-bit universal shift register with multi-step shift engine
// Ports: clk, reset (async active-low), in (load data), mode (command), amt (step count),
//        start (strobe, honoured in IDLE), sin (serial fill), out (register), sout (exit bit),
//        busy (stepping), done (one-cycle completion pulse).
module universal_shift_register
   import universal_shift_register_pkg::*;
#(
   parameter int N  = 16,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  in,
   input  logic [2:0]    mode,
   input  logic [CW-1:0] amt,
   input  logic          start,
   input  logic          sin,
   output logic [N-1:0]  out,
   output logic          sout,
   output logic          busy,
   output logic          done
);
   state_t        state;
   mode_t         op;
   logic [CW-1:0] cnt;
   logic [N-1:0]  nxt;
   logic          bout;
   logic          is_shift;
   assign is_shift = (mode >= 3'd2) && (mode <= 3'd6);
   shift_step_unit #(.N(N)) u_step (
      .cur  (out),
      .mode (op),
      .sin  (sin),
      .nxt  (nxt),
      .bout (bout)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= ST_IDLE;
         op    <= MODE_NOP;
         cnt   <= '0;
         out   <= '0;
         sout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               if (mode_t'(mode) == MODE_LOAD) begin
                  out  <= in;
                  sout <= 1'b0;
                  done <= 1'b1;
               end else if (is_shift && amt != '0) begin
                  op    <= mode_t'(mode);
                  cnt   <= amt;
                  state <= ST_SHIFT;
                  busy  <= 1'b1;
               end else begin
                  done <= 1'b1;
               end
            end
         end else begin
            out  <= nxt;
            sout <= bout;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
endmodule
